// File: rtl/seg_pkg.sv
// Shared types, segment patterns and BCD decode for the seven-segment scan controller.
package seg_pkg;

  typedef enum logic {
    SCAN  = 1'b0,
    GUARD = 1'b1
  } state_t;

  // Active-low patterns, index 0 = segment a ... index 6 = segment g.
  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001101;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  function automatic logic [0:6] seg_decode(input logic [3:0] bcd);
    logic [0:6] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame update channel into the scan controller.
// Handshake: a frame moves on any rising clk edge where upd_valid && upd_ready are both 1;
// upd_data is only meaningful on such an edge, and upd_ready never depends on upd_valid.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    upd_valid;
  logic                    upd_ready;
  logic [4*NUM_DIGITS-1:0] upd_data;

  modport master (output upd_valid, output upd_data, input upd_ready);
  modport slave  (input upd_valid, input upd_data, output upd_ready);
endinterface

// File: rtl/seg_decoder.sv
// Combinational BCD digit to active-low segment pattern; codes 10..15 come out dark.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [0:6] seg
);
  assign seg = seg_decode(bcd);
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered BCD frame input.
// Optional leading-zero suppression is built when SEG_LZ_SUPPRESS_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD_CYC  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  seg_scan_ctrl_if.slave                upd,
  input  logic                          blank,
  output logic [0:6]                    led,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_done,
  output state_t                        state
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(SCAN_DIV + GUARD_CYC + 1);
  localparam logic [CW-1:0]         SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]         GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [IW-1:0]         LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT    = NUM_DIGITS'(1);

  state_t                  state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx_nxt;
  logic                    advance, wrap;
  logic                    ready_en, pending, xfer;
  logic [4*NUM_DIGITS-1:0] shadow, active;
  logic [3:0]              cur_digit;
  logic [0:6]              cur_seg;
  logic                    suppress;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SCAN;
      cnt      <= '0;
      scan_idx <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      scan_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = scan_idx;
    advance   = 1'b0;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_nxt = '0;
          if (GUARD_CYC == 0) advance = 1'b1;
          else                state_nxt = GUARD;
        end
      end
      GUARD: begin
        if (cnt == GUARD_LAST) advance = 1'b1;
      end
      default: state_nxt = SCAN;
    endcase
    if (advance) begin
      state_nxt = SCAN;
      cnt_nxt   = '0;
      idx_nxt   = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
    end
  end

  assign wrap       = advance && (scan_idx == LAST_IDX);
  assign frame_done = wrap;

  // Ready is held low while reset is asserted and comes up on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign upd.upd_ready = ready_en && !pending;
  assign xfer          = upd.upd_valid && upd.upd_ready;

  // Active only changes at the wrap, so a frame is never shown half old, half new.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (wrap && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end else if (xfer) begin
      shadow  <= upd.upd_data;
      pending <= 1'b1;
    end
  end

  assign cur_digit = active[4*scan_idx +: 4];

  seg_decoder u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

`ifdef SEG_LZ_SUPPRESS_EN
  // Walk down from the top digit; the run of zeros above the first non-zero digit goes dark.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    suppress   = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (active[4*i +: 4] == 4'd0);
      if ((scan_idx == IW'(i)) && upper_zero) suppress = 1'b1;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= '1;
      led <= SEG_BLANK;
    end else if (state == GUARD || blank) begin
      an  <= '1;
      led <= SEG_BLANK;
    end else begin
      an  <= ~(ONE_HOT << scan_idx);
      led <= suppress ? SEG_BLANK : cur_seg;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with 4 digits, 4-cycle dwell and 1-cycle guard (20-cycle frame).
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int ND = 4;
  localparam int FRAME = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       blank;
  logic [0:6] led;
  logic [3:0] an;
  logic [1:0] scan_idx;
  logic       frame_done;
  state_t     state;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) upd_if ();

  seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(4), .GUARD_CYC(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .upd        (upd_if),
    .blank      (blank),
    .led        (led),
    .an         (an),
    .scan_idx   (scan_idx),
    .frame_done (frame_done),
    .state      (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // expected {an, led, frame_done, upd_ready, scan_idx} after each edge
  logic [14:0] exp_q[$];

  int          t;
  logic        m_pending;
  logic [15:0] m_active, m_shadow;

  function automatic logic [0:6] ref_dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001101;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic lz_dark(input int k, input logic [15:0] frame);
`ifdef SEG_LZ_SUPPRESS_EN
    logic z;
    z = 1'b1;
    for (int i = k; i < ND; i++) z = z && (frame[4*i +: 4] == 4'd0);
    return (k > 0) && z;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // driver: apply inputs for the next edge, push the response expected after it
  task automatic step(input logic v, input logic [15:0] d, input logic b, output logic took);
    logic       rdy, xfer, wrap, fd_e, rdy_e;
    int         p, dig;
    logic [3:0] an_e;
    logic [0:6] led_e;
    logic [1:0] idx_e;
    upd_if.upd_valid = v;
    upd_if.upd_data  = d;
    blank            = b;
    rdy  = (t >= 1) && !m_pending;
    xfer = v && rdy;
    wrap = ((t + 1) % FRAME) == 0;
    p    = t % FRAME;
    dig  = p / 5;
    if ((p % 5) < 4 && !b) begin
      an_e  = ~(4'b0001 << dig);
      led_e = lz_dark(dig, m_active) ? 7'b1111111 : ref_dec(m_active[4*dig +: 4]);
    end else begin
      an_e  = 4'b1111;
      led_e = 7'b1111111;
    end
    fd_e  = ((t + 1) % FRAME) == FRAME - 1;
    idx_e = 2'(((t + 1) % FRAME) / 5);
    if (wrap && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end else if (xfer) begin
      m_shadow  = d;
      m_pending = 1'b1;
    end
    rdy_e = !m_pending;
    exp_q.push_back({an_e, led_e, fd_e, rdy_e, idx_e});
    @(posedge clk);
    #1;
    t++;
    took = xfer;
  endtask

  task automatic idle(input int n);
    logic tk;
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, tk);
  endtask

  // monitor
  initial begin
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({an, led, frame_done, upd_if.upd_ready, scan_idx} !== e) begin
          n_errors++;
          $display("FAIL out_t%0d: got an=%b led=%b fd=%b rdy=%b idx=%0d expected an=%b led=%b fd=%b rdy=%b idx=%0d",
                   t, an, led, frame_done, upd_if.upd_ready, scan_idx,
                   e[14:11], e[10:4], e[3], e[2], e[1:0]);
        end
      end
    end
  end

  initial begin
    logic tk;
    int   guard;
    reset = 1'b0;
    blank = 1'b0;
    upd_if.upd_valid = 1'b0;
    upd_if.upd_data  = 16'h0000;
    t = 0; m_pending = 1'b0; m_active = '0; m_shadow = '0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_led", 32'(led), 32'h7F);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_scan_idx", 32'(scan_idx), 32'h0);
    check("rst_state", 32'(state), 32'(SCAN));
    reset = 1'b1;

    // idle frames: all digits show 0
    idle(47);

    // single transfer mid-frame
    step(1'b1, 16'h9876, 1'b0, tk);
    idle(45);

    // 1234 accepted, 5678 held until the shadow frees up at the wrap
    step(1'b1, 16'h1234, 1'b0, tk);
    guard = 0;
    do begin
      step(1'b1, 16'h5678, 1'b0, tk);
      guard++;
    end while (!tk && guard < 60);
    check("hold_5678_accepted", 32'(tk), 32'h1);
    idle(45);

    // offer on the exact wrap edge with nothing pending
    guard = 0;
    while (!(((t + 1) % FRAME) == 0 && !m_pending) && guard < 40) begin
      idle(1);
      guard++;
    end
    step(1'b1, 16'h3C50, 1'b0, tk);
    idle(25);

    // blank pulses while the C digit frame is on screen
    for (int i = 0; i < 30; i++) step(1'b0, 16'h0000, (i % 7) < 3, tk);
    idle(10);

    // transfer just after a wrap, then reset inside the following guard slot
    guard = 0;
    while ((t % FRAME) != 1 && guard < 40) begin
      idle(1);
      guard++;
    end
    step(1'b1, 16'h0040, 1'b0, tk);
    guard = 0;
    while (!((t % 5) == 4 && m_pending) && guard < 10) begin
      idle(1);
      guard++;
    end
    check("guard_state_before_reset", 32'(state), 32'(GUARD));
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_led", 32'(led), 32'h7F);
    check("midrst_scan_idx", 32'(scan_idx), 32'h0);
    check("midrst_state", 32'(state), 32'(SCAN));
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    t = 0; m_pending = 1'b0; m_active = '0; m_shadow = '0;
    idle(22);

    // 0040 frame after reset
    step(1'b1, 16'h0040, 1'b0, tk);
    idle(45);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
